// File: rtl/serial_and_engine.sv
// Bit-serial AND engine: captures two operands, emits their AND one bit per
// cycle LSB first, then presents the assembled parallel result on andout.
module serial_and_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done,
  output logic [WIDTH-1:0] andout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;

  logic             b_c;
  logic [WIDTH-1:0] res_next_c;

  // Current serial bit and the result after it is shifted in at the MSB end.
  assign b_c        = sa[0] & sb[0];
  assign res_next_c = {b_c, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      andout    <= '0;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          bit_valid <= 1'b0;
          if (start) begin
            sa    <= ina;
            sb    <= inb;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sa        <= sa >> 1;
          sb        <= sb >> 1;
          res       <= res_next_c;
          bit_out   <= b_c;
          bit_valid <= 1'b1;
          // Counter stops at LAST so it never wraps inside an operation.
          if (cnt == LAST) begin
            andout <= res_next_c;
            done   <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            cnt  <= cnt + CW'(1);
            done <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/serial_and_engine.md
SERIAL_AND_ENGINE -- requirements
Module: serial_and_engine

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 16, operand/result width in bits (legal range 2..64).
REQ-002 The module SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have a port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have a port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The module SHALL have a port ina, input, WIDTH bits: operand A; captured on the accepted start edge.
REQ-006 The module SHALL have a port inb, input, WIDTH bits: operand B; captured on the accepted start edge.
REQ-007 The module SHALL have a port busy, output, 1 bit: high while in RUN.
REQ-008 The module SHALL have a port bit_out, output, 1 bit: registered serial result bit, LSB first.
REQ-009 The module SHALL have a port bit_valid, output, 1 bit: qualifies bit_out.
REQ-010 The module SHALL have a port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The module SHALL have a port andout, output, WIDTH bits: parallel result ina&inb of the last completed operation.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN; busy = (state==RUN).
REQ-013 In IDLE with start=1 at edge E0, the module SHALL load ina and inb into internal shift registers, clear the bit counter and the result register, and enter RUN.
REQ-014 In IDLE with start=0, the module SHALL hold all registers except done and bit_valid, which go to 0.
REQ-015 At each RUN edge Ek (k=1..WIDTH), the module SHALL compute b = sa[0]&sb[0], right-shift sa and sb by one, shift b into result at the MSB end (right shift), register bit_out=b and bit_valid=1, and increment the counter.
REQ-016 At edge E_WIDTH (counter == WIDTH-1), the module SHALL write the completed result to andout, set done=1 for exactly one cycle, and return to IDLE.
REQ-017 Latency: bit_valid SHALL be high for exactly WIDTH consecutive cycles following E1..E_WIDTH; done SHALL be high in the same cycle as the final bit_valid.
REQ-018 andout SHALL equal ina&inb as captured at E0, bit for bit, and SHALL hold until the next completion.
REQ-019 start asserted while in RUN SHALL be ignored: no operand reload and no effect on the counter or outputs.
REQ-020 start asserted in the cycle where done=1 (state already IDLE) SHALL be accepted, giving back-to-back operations every WIDTH+1 cycles.
REQ-021 Changes on ina/inb after E0 SHALL NOT affect the running operation.
REQ-022 The counter SHALL be clog2(WIDTH) bits and SHALL never wrap within an operation.

Reset
REQ-023 With rst=1 at a rising edge, the module SHALL enter IDLE and set busy=0, done=0, bit_valid=0, bit_out=0, andout=0, and clear the counter and shift registers.
REQ-024 rst SHALL take priority over start and over RUN activity.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse, and andout SHALL be 0.
REQ-026 The first start after reset release SHALL be accepted normally.

Verification
REQ-027 The bench SHALL cover this case: WIDTH=16, ina=16'hFFFF, inb=16'h0F0F, start one cycle -> bit_out 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 over 16 valid cycles; done with andout=16'h0F0F.
REQ-028 The bench SHALL cover this case: ina=16'hA5A5, inb=16'h5A5A -> all 16 bits 0; andout=16'h0000; done exactly 1 cycle; busy high 16 cycles.
REQ-029 The bench SHALL cover this case: start with ina=16'h1234, inb=16'hFFFF, then start again at RUN cycle 3 with ina=16'h0000 -> ignored; andout=16'h1234.
REQ-030 The bench SHALL cover this case: start with ina=16'hFFFF, inb=16'hFFFF, then rst at RUN cycle 5 -> busy, bit_valid and andout go to 0 the next cycle; no done pulse; a subsequent start completes with 16'hFFFF.
REQ-031 The bench SHALL cover this case: start held high continuously with operands 16'h00FF/16'hFFFF, then 16'hF0F0/16'h3C3C -> done pulses 17 cycles apart; andout=16'h00FF, then 16'h3030.
REQ-032 The bench SHALL cover this case: WIDTH=8, ina=8'hC3, inb=8'h81 -> andout=8'h81; bit_valid high 8 cycles.
